// File: rtl/dual_rail_cipher_capture_if.sv
// Handshake and data bundle between an AES256 dual-rail core and its ciphertext capture block.
interface dual_rail_cipher_capture_if #(
    parameter int unsigned N = 128
);
    logic         Start;
    logic [N-1:0] Core_T;
    logic [N-1:0] Core_F;
    logic [N-1:0] Cipher_in_T;
    logic [N-1:0] Cipher_in_F;
    logic         Done;
    logic         flipflpoindicator;
    logic         Error;
    logic         Timeout;
    logic [15:0]  Latency;

    modport master (
        output Start, Core_T, Core_F,
        input  Cipher_in_T, Cipher_in_F, Done, flipflpoindicator, Error, Timeout, Latency
    );

    modport slave (
        input  Start, Core_T, Core_F,
        output Cipher_in_T, Cipher_in_F, Done, flipflpoindicator, Error, Timeout, Latency
    );
endinterface

// File: rtl/dual_rail_cipher_capture.sv
// Captures a dual-rail ciphertext once the codeword has been valid for STABLE consecutive cycles,
// with illegal-code fault latching and an evaluation timeout.
module dual_rail_cipher_capture #(
    parameter int unsigned N       = 128,
    parameter int unsigned STABLE  = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic                       Clk,
    input logic                       Reset,
    dual_rail_cipher_capture_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StWaitSpacer, StEval, StHold, StFault} state_e;

    state_e       state_q, state_d;
    logic [15:0]  eval_q, eval_d;
    logic [2:0]   stable_q, stable_d;
    logic [3:0]   stable_inc;
    logic [N-1:0] cipher_t_q, cipher_f_q;
    logic [15:0]  latency_q;
    logic         done_q, ind_q, error_q, timeout_q;

    logic code_spacer, code_valid, code_illegal;
    logic capture, set_error, set_timeout, clr_ind;

    assign code_spacer  = (bus.Core_T == '0) && (bus.Core_F == '0);
    assign code_valid   = &(bus.Core_T ^ bus.Core_F);
    assign code_illegal = |(bus.Core_T & bus.Core_F);
    assign stable_inc   = {1'b0, stable_q} + 4'd1;

    always_comb begin
        state_d     = state_q;
        eval_d      = eval_q;
        stable_d    = stable_q;
        capture     = 1'b0;
        set_error   = 1'b0;
        set_timeout = 1'b0;
        clr_ind     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d = StWaitSpacer;
                    clr_ind = 1'b1;
                end
            end
            // Precharge transients may look illegal here; only a clean spacer arms evaluation.
            StWaitSpacer: begin
                if (code_spacer) begin
                    state_d  = StEval;
                    eval_d   = '0;
                    stable_d = '0;
                end
            end
            StEval: begin
                eval_d = (eval_q == 16'hFFFF) ? eval_q : eval_q + 16'd1;
                if (code_illegal) begin
                    state_d   = StFault;
                    set_error = 1'b1;
                end else if (code_valid) begin
                    stable_d = stable_inc[2:0];
                    if (stable_inc == 4'(STABLE)) begin
                        capture = 1'b1;
                        state_d = StHold;
                    end
                end else begin
                    stable_d = '0;
                end
                if (!code_illegal && !capture && (eval_q == 16'(TIMEOUT))) begin
                    set_timeout = 1'b1;
                    state_d     = StIdle;
                end
            end
            StHold:  state_d = StIdle;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            eval_q     <= '0;
            stable_q   <= '0;
            cipher_t_q <= '0;
            cipher_f_q <= '1;
            latency_q  <= '0;
            done_q     <= 1'b0;
            ind_q      <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            eval_q   <= eval_d;
            stable_q <= stable_d;
            done_q   <= capture;
            if (capture) begin
                cipher_t_q <= bus.Core_T;
                cipher_f_q <= bus.Core_F;
                latency_q  <= eval_q;
            end
            if (capture) begin
                ind_q <= 1'b1;
            end else if (clr_ind) begin
                ind_q <= 1'b0;
            end
            if (set_error) begin
                error_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.Cipher_in_T       = cipher_t_q;
    assign bus.Cipher_in_F       = cipher_f_q;
    assign bus.Latency           = latency_q;
    assign bus.Done              = done_q;
    assign bus.flipflpoindicator = ind_q;
    assign bus.Error             = error_q;
    assign bus.Timeout           = timeout_q;
endmodule

// File: tb/tb_dual_rail_cipher_capture.sv
// Directed bench for dual_rail_cipher_capture; captures are checked against a scoreboard queue.
module tb_dual_rail_cipher_capture;
    localparam int unsigned N = 128;

    typedef struct {
        logic [N-1:0] t;
        logic [N-1:0] f;
        logic [15:0]  lat;
    } cap_t;

    logic Clk;
    logic Reset;
    int   n_cmp = 0;
    int   n_err = 0;
    cap_t exp_q[$];

    localparam logic [N-1:0] T0 = 128'h0ac204a018dea065bb094af9225cd4b7;
    localparam logic [N-1:0] F0 = 128'hf53dfb5fe7215f9a44f6b506dda32b48;
    localparam logic [N-1:0] T1 = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [N-1:0] F1 = ~T1;
    localparam logic [N-1:0] ALL1 = {N{1'b1}};

    dual_rail_cipher_capture_if #(.N(N)) bus ();

    dual_rail_cipher_capture #(
        .N      (N),
        .STABLE (2),
        .TIMEOUT(8)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_code(input logic [N-1:0] t, input logic [N-1:0] f);
        bus.Core_T = t;
        bus.Core_F = f;
    endtask

    // Three spacer cycles (idle, Start, wait-spacer); returns in the first EVAL cycle.
    task automatic start_eval();
        set_code('0, '0);
        step();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        step();
    endtask

    task automatic check_reset_values();
        check("rst_cipher_t", bus.Cipher_in_T, '0);
        check("rst_cipher_f", bus.Cipher_in_F, ALL1);
        check("rst_done", N'(bus.Done), '0);
        check("rst_ind", N'(bus.flipflpoindicator), '0);
        check("rst_error", N'(bus.Error), '0);
        check("rst_timeout", N'(bus.Timeout), '0);
        check("rst_latency", N'(bus.Latency), '0);
    endtask

    // Scoreboard: every Done pulse must match the oldest expected capture.
    always @(negedge Clk) begin
        if (bus.Done === 1'b1) begin
            check("done_expected", N'(exp_q.size() != 0), N'(1));
            if (exp_q.size() != 0) begin
                cap_t e;
                e = exp_q.pop_front();
                check("cap_cipher_t", bus.Cipher_in_T, e.t);
                check("cap_cipher_f", bus.Cipher_in_F, e.f);
                check("cap_latency", N'(bus.Latency), N'(e.lat));
                check("cap_ind", N'(bus.flipflpoindicator), N'(1));
            end
        end
    end

    initial begin
        int waited;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        set_code('0, '0);
        step();
        step();
        Reset = 1'b0;
        check_reset_values();

        // Nominal capture on the second valid cycle.
        start_eval();
        set_code(T0, F0);
        exp_q.push_back('{T0, F0, 16'd1});
        step();
        check("no_early_done", N'(bus.Done), '0);
        step();
        check("nom_done", N'(bus.Done), N'(1));
        check("nom_ind", N'(bus.flipflpoindicator), N'(1));
        step();
        check("done_single_cycle", N'(bus.Done), '0);
        check("ind_held", N'(bus.flipflpoindicator), N'(1));

        // Glitch filter, then Start during HOLD.
        start_eval();
        check("ind_drop_on_start", N'(bus.flipflpoindicator), '0);
        set_code(T1, F1);
        step();
        set_code(T1, F1 & {1'b0, {(N - 1) {1'b1}}});
        step();
        set_code(T1, F1);
        exp_q.push_back('{T1, F1, 16'd3});
        step();
        step();
        check("glitch_done", N'(bus.Done), N'(1));
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        check("hold_start_ind", N'(bus.flipflpoindicator), N'(1));
        step();
        step();
        check("hold_start_ignored", N'(bus.flipflpoindicator), N'(1));
        check("idle_no_done", N'(bus.Done), '0);

        // Timeout with an all-zero hold; earlier capture must survive.
        start_eval();
        for (int i = 0; i < 7; i++) step();
        check("timeout_not_early", N'(bus.Timeout), '0);
        waited = 0;
        while (bus.Timeout !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        check("timeout_set", N'(bus.Timeout), N'(1));
        check("timeout_keep_t", bus.Cipher_in_T, T1);
        check("timeout_keep_f", bus.Cipher_in_F, F1);
        check("timeout_keep_lat", N'(bus.Latency), N'(3));
        check("timeout_ind", N'(bus.flipflpoindicator), '0);
        start_eval();
        set_code(T0, F0);
        exp_q.push_back('{T0, F0, 16'd1});
        step();
        step();
        step();
        check("timeout_sticky", N'(bus.Timeout), N'(1));

        // Illegal code: ignored while waiting for spacer, faults in EVAL.
        set_code('0, '0);
        step();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        set_code(N'(1), N'(1));
        step();
        check("wait_ignores_illegal", N'(bus.Error), '0);
        set_code('0, '0);
        step();
        set_code(T0, F0);
        step();
        set_code(N'(1), N'(1));
        step();
        check("error_set", N'(bus.Error), N'(1));
        check("fault_ind", N'(bus.flipflpoindicator), '0);
        start_eval();
        set_code(T1, F1);
        for (int i = 0; i < 5; i++) step();
        check("fault_sticky", N'(bus.Error), N'(1));
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("error_cleared", N'(bus.Error), '0);

        // Reset in the second valid cycle, with Start also asserted.
        start_eval();
        set_code(T1, F1);
        exp_q.push_back('{T1, F1, 16'd1});
        step();
        step();
        step();
        start_eval();
        set_code(T0, F0);
        step();
        Reset     = 1'b1;
        bus.Start = 1'b1;
        step();
        Reset     = 1'b0;
        bus.Start = 1'b0;
        check_reset_values();
        step();
        step();
        check("post_reset_no_done", N'(bus.Done), '0);

        check("queue_drained", N'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
